// File: rtl/pc_pkg.sv
// Shared types, counter encodings and saturating-counter helpers for the fetch PC generator.
// BTB entries use 2-bit direction counters; bit 1 is the predicted direction.
package pc_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;  // strongly not taken
    localparam ctr_t CTR_WNT = 2'd1;  // weakly not taken
    localparam ctr_t CTR_WT  = 2'd2;  // weakly taken (initial state on allocation)
    localparam ctr_t CTR_ST  = 2'd3;  // strongly taken

    // Saturating increment towards strongly-taken.
    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    endfunction

    // Saturating decrement towards strongly-not-taken.
    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: one lookup port (current fetch PC) and one training port.
// A lookup in the same cycle as a write to the same index sees the pre-write contents.
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned BTB_TAG_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc_i,
    input  logic [XLEN-1:0] pc_add4_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_en_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_LSB = 2 + IDX_W;

    // The entry struct depends on module parameters, so it is declared here rather than in pc_pkg.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [XLEN-3:0]      target;
        ctr_t                 ctr;
    } btb_entry_t;

    btb_entry_t entries_q [BTB_ENTRIES];
    btb_entry_t entries_d [BTB_ENTRIES];

    logic [IDX_W-1:0]     lk_idx, up_idx;
    logic [BTB_TAG_W-1:0] lk_tag, up_tag;
    btb_entry_t           lk_entry, up_entry;
    logic                 lk_hit, up_hit;

    assign lk_idx = lookup_pc_i[2 +: IDX_W];
    assign lk_tag = lookup_pc_i[TAG_LSB +: BTB_TAG_W];
    assign up_idx = upd_pc_i[2 +: IDX_W];
    assign up_tag = upd_pc_i[TAG_LSB +: BTB_TAG_W];

    // Address bits outside index/tag and the ignored target LSBs.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc_i, upd_pc_i, upd_target_i[1:0]};

    // Lookup: predict taken on a tag hit whose counter leans taken.
    always_comb begin
        lk_entry      = entries_q[lk_idx];
        lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
        pred_taken_o  = lk_hit && lk_entry.ctr[1];
        pred_target_o = pred_taken_o ? {lk_entry.target, 2'b00} : pc_add4_i;
    end

    // Training: allocate on taken miss, train counter on hit, ignore not-taken miss.
    always_comb begin
        entries_d = entries_q;
        up_entry  = entries_q[up_idx];
        up_hit    = up_entry.valid && (up_entry.tag == up_tag);
        if (upd_en_i) begin
            if (upd_taken_i) begin
                entries_d[up_idx].valid  = 1'b1;
                entries_d[up_idx].tag    = up_tag;
                entries_d[up_idx].target = upd_target_i[XLEN-1:2];
                entries_d[up_idx].ctr    = up_hit ? ctr_inc(up_entry.ctr) : CTR_WT;
            end else if (up_hit) begin
                entries_d[up_idx].ctr = ctr_dec(up_entry.ctr);
            end
        end
    end

    // Entry array; reset clears every entry so all valid bits drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '{default: '0};
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with optional BTB next-PC prediction.
// Define PC_BTB_EN to build the BTB; otherwise the PC advances by 4 unless stalled/redirected.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16,
    parameter int unsigned     BTB_TAG_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_add4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q, pc_d;

    assign pc      = pc_q;
    assign pc_add4 = pc_q + XLEN'(4);

`ifdef PC_BTB_EN
    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .BTB_TAG_W   (BTB_TAG_W)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc_i   (pc_q),
        .pc_add4_i     (pc_add4),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_en_i      (upd_en),
        .upd_pc_i      (upd_pc),
        .upd_taken_i   (upd_taken),
        .upd_target_i  (upd_target)
    );
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc_add4;

    logic unused_upd;
    assign unused_upd = ^{upd_en, upd_pc, upd_taken, upd_target};
`endif

    // Redirect target LSBs are forced to zero.
    logic unused_rpc_lsb;
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Next-PC select: redirect beats stall, stall holds, else follow the prediction.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc_d = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a
// behavioural next-PC / BTB model. Works with PC_BTB_EN defined or undefined.
module tb_pc_gen;

    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0;
    localparam int unsigned ENT   = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned TAG_W = 8;
`ifdef PC_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0, upd_en = 1'b0, upd_taken = 1'b0;
    logic [31:0] redirect_pc = '0, upd_pc = '0, upd_target = '0;
    logic [31:0] pc, pc_add4, pred_target;
    logic        pred_taken;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .BTB_ENTRIES  (ENT),
        .BTB_TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .pc          (pc),
        .pc_add4     (pc_add4),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    // Reference model state: fetch PC plus a table of BTB entries.
    logic [31:0] m_pc;
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % ENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a / (4 * ENT)) % (1 << TAG_W);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return BTB_ON && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic m_lookup(input logic [31:0] a, output bit t, output logic [31:0] tg);
        t  = m_hit(a) && (m_ctr[idx_of(a)] >= 2);
        tg = t ? m_tgt[idx_of(a)] : a + 32'd4;
    endtask

    task automatic m_reset();
        m_pc = RV;
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic m_edge();
        bit          t;
        logic [31:0] tg, nxt;
        int unsigned i;
        m_lookup(m_pc, t, tg);
        if (redirect)   nxt = redirect_pc & ~32'h3;
        else if (stall) nxt = m_pc;
        else            nxt = tg;
        if (BTB_ON && upd_en) begin
            i = idx_of(upd_pc);
            if (upd_taken) begin
                m_ctr[i]   = m_hit(upd_pc) ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : 2;
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(upd_pc);
                m_tgt[i]   = upd_target & ~32'h3;
            end else if (m_hit(upd_pc)) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end
        m_pc = nxt;
    endtask

    task automatic compare_outputs();
        bit          t;
        logic [31:0] tg;
        m_lookup(m_pc, t, tg);
        check_eq("pc", pc, m_pc);
        check_eq("pc_add4", pc_add4, m_pc + 32'd4);
        check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, t});
        check_eq("pred_target", pred_target, tg);
    endtask

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic clear_in();
        stall = 0; redirect = 0; redirect_pc = '0;
        upd_en = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
    endtask

    task automatic go(input logic [31:0] a);
        clear_in();
        redirect = 1; redirect_pc = a;
        step();
        redirect = 0;
    endtask

    task automatic train(input logic [31:0] a, input bit tk, input logic [31:0] tg);
        clear_in();
        upd_en = 1; upd_pc = a; upd_taken = tk; upd_target = tg;
        step();
        clear_in();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must respond before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("rst_pc", pc, RV);
        check_eq("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check_eq("rst_pred_target", pred_target, RV + 32'd4);
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        clear_in();
        m_reset();
        #12;
        do_reset();

        // Free-run then stall at 0x10, then redirect overriding stall.
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("free_run", pc, 32'(4 * (i + 1)));
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_hold", pc, 32'h10);
        end
        redirect = 1; redirect_pc = 32'h200;
        step();
        check_eq("redirect_over_stall", pc, 32'h200);
        clear_in();

        // Train 0x40 taken -> 0x100 (target LSBs must be dropped).
        train(32'h40, 1'b1, 32'h101);
        go(32'h40);
        check_eq("train_pred", {31'd0, pred_taken}, {31'd0, BTB_ON});
        step();
        check_eq("train_next", pc, BTB_ON ? 32'h100 : 32'h44);

        // Two not-taken updates drop the prediction.
        train(32'h40, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        go(32'h40);
        check_eq("untrain_target", pred_target, 32'h44);
        step();

        // Alias: 0x80 shares index with 0x40 and replaces it.
        train(32'h40, 1'b1, 32'h100);
        train(32'h80, 1'b1, 32'h300);
        go(32'h40);
        check_eq("alias_old", pred_target, 32'h44);
        go(32'h80);
        check_eq("alias_new", pred_target, BTB_ON ? 32'h300 : 32'h84);
        step();

        // Same-cycle lookup/allocate at 0x40 sees the old (empty) entry.
        do_reset();
        go(32'h40);
        upd_en = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h100;
        check_eq("hazard_old", {31'd0, pred_taken}, 32'd0);
        step();
        clear_in();
        go(32'h40);
        check_eq("hazard_new", {31'd0, pred_taken}, {31'd0, BTB_ON});
        step();

        // Wrap at the top of the address space.
        do_reset();
        go(32'hFFFF_FFFC);
        check_eq("wrap_add4", pc_add4, 32'h0);
        step();
        check_eq("wrap_pc", pc, 32'h0);

        // Randomized traffic, with one reset landing during an update.
        for (int c = 0; c < 400; c++) begin
            stall       = ($urandom % 5) == 0;
            redirect    = ($urandom % 8) == 0;
            redirect_pc = (($urandom % 16) == 0) ? $urandom : ($urandom & 32'h7FF);
            upd_en      = $urandom % 2;
            upd_pc      = (($urandom % 2) == 0) ? m_pc : ($urandom & 32'h7FC);
            upd_taken   = $urandom % 2;
            upd_target  = $urandom & 32'h7FF;
            if (c == 200) begin
                upd_en = 1;
                do_reset();
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
